// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-word RAM behind an SPI slave with burst
// auto-increment, optional read output stage and illegal-sequence flag.
module spi_ram_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AUTO_INC   = 1,
    parameter int RD_PIPE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  err
);

    typedef enum logic [1:0] {
        OP_WADDR = 2'b00,
        OP_WDATA = 2'b01,
        OP_RADDR = 2'b10,
        OP_RDATA = 2'b11
    } op_e;

    localparam logic [DATA_WIDTH:0]   DEPTH_W = (DATA_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    op_e                   op;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  addr_ok;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  wr_armed_q, wr_armed_d;
    logic                  rd_armed_q, rd_armed_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s_vld;
    logic [DATA_WIDTH-1:0] s_data;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q;

    assign op      = op_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = din[DATA_WIDTH-1:0];
    assign paddr   = payload[ADDR_WIDTH-1:0];
    // Full-width compare also rejects any nonzero bits above the address field.
    assign addr_ok = {1'b0, payload} < DEPTH_W;

    function automatic logic [ADDR_WIDTH-1:0] bump(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        rd_fire    = 1'b0;
        if (rx_valid) begin
            case (op)
                OP_WADDR: begin
                    if (addr_ok) begin
                        wr_ptr_d   = paddr;
                        wr_armed_d = 1'b1;
                    end else begin
                        wr_armed_d = 1'b0;
                        err_d      = 1'b1;
                    end
                end
                OP_WDATA: begin
                    if (wr_armed_q) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) wr_ptr_d = bump(wr_ptr_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RADDR: begin
                    if (addr_ok) begin
                        rd_ptr_d   = paddr;
                        rd_armed_d = 1'b1;
                    end else begin
                        rd_armed_d = 1'b0;
                        err_d      = 1'b1;
                    end
                end
                OP_RDATA: begin
                    if (rd_armed_q) begin
                        rd_fire = 1'b1;
                        if (AUTO_INC != 0) rd_ptr_d = bump(rd_ptr_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= payload;
    end

    assign rd_word = mem_q[rd_ptr_q];

    if (RD_PIPE != 0) begin : g_pipe
        logic                  pipe_vld_q;
        logic [DATA_WIDTH-1:0] pipe_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_vld_q  <= 1'b0;
                pipe_data_q <= '0;
            end else begin
                pipe_vld_q <= rd_fire;
                if (rd_fire) pipe_data_q <= rd_word;
            end
        end

        assign s_vld  = pipe_vld_q;
        assign s_data = pipe_data_q;
    end else begin : g_direct
        assign s_vld  = rd_fire;
        assign s_data = rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= s_vld;
            if (s_vld) dout_q <= s_data;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: two configurations driven in lockstep and
// checked every cycle against a behavioural command-level model.
module tb_spi_ram_burst;

    localparam int NS = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       tx_a, tx_b, err_a, err_b;

    int errors = 0;
    int checks = 0;
    bit start  = 1'b0;

    always #5 clk = ~clk;

    // A: DEPTH=200, auto-increment, direct output.
    spi_ram_burst #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200),
        .AUTO_INC(1), .RD_PIPE(0)
    ) u_a (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dout_a), .tx_valid(tx_a), .err(err_a)
    );

    // B: DEPTH=256, pointer holds, extra output stage.
    spi_ram_burst #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256),
        .AUTO_INC(0), .RD_PIPE(1)
    ) u_b (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dout_b), .tx_valid(tx_b), .err(err_b)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] mm [2][256];
    int         wp [2];
    int         rp [2];
    bit         wa [2];
    bit         ra [2];
    bit         sv [2][NS];
    logic [7:0] sd [2][NS];
    bit         m_tx  [2];
    bit         m_err [2];
    logic [7:0] m_dout[2];
    int         ncyc = 0;

    function automatic int dep_of(int k);
        return (k == 0) ? 200 : 256;
    endfunction

    function automatic int ai_of(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                wp[k] = 0; rp[k] = 0; wa[k] = 0; ra[k] = 0;
                m_tx[k] = 0; m_err[k] = 0; m_dout[k] = 8'h00;
                for (int s = 0; s < NS; s++) sv[k][s] = 0;
            end
        end else begin
            ncyc++;
            for (int k = 0; k < 2; k++) begin
                int op;
                int pl;
                int slot;
                op = int'(din[9:8]);
                pl = int'(din[7:0]);
                m_err[k] = 0;
                if (rx_valid) begin
                    case (op)
                        0: if (pl < dep_of(k)) begin
                               wp[k] = pl; wa[k] = 1;
                           end else begin
                               wa[k] = 0; m_err[k] = 1;
                           end
                        1: if (wa[k]) begin
                               mm[k][wp[k]] = pl[7:0];
                               if (ai_of(k) != 0) wp[k] = (wp[k] + 1) % dep_of(k);
                           end else begin
                               m_err[k] = 1;
                           end
                        2: if (pl < dep_of(k)) begin
                               rp[k] = pl; ra[k] = 1;
                           end else begin
                               ra[k] = 0; m_err[k] = 1;
                           end
                        default: if (ra[k]) begin
                               slot = (ncyc + lat_of(k)) % NS;
                               sv[k][slot] = 1;
                               sd[k][slot] = mm[k][rp[k]];
                               if (ai_of(k) != 0) rp[k] = (rp[k] + 1) % dep_of(k);
                           end else begin
                               m_err[k] = 1;
                           end
                    endcase
                end
                slot = ncyc % NS;
                m_tx[k] = sv[k][slot];
                if (sv[k][slot]) m_dout[k] = sd[k][slot];
                sv[k][slot] = 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start) begin
            chk("a_tx",   int'(tx_a),   int'(m_tx[0]));
            chk("a_err",  int'(err_a),  int'(m_err[0]));
            chk("a_dout", int'(dout_a), int'(m_dout[0]));
            chk("b_tx",   int'(tx_b),   int'(m_tx[1]));
            chk("b_err",  int'(err_b),  int'(m_err[1]));
            chk("b_dout", int'(dout_b), int'(m_dout[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int op, input int pl);
        @(negedge clk);
        rx_valid = 1'b1;
        din = {op[1:0], pl[7:0]};
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        din = 10'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b1;

        // read-data before any read-address
        step(3, 0);
        idle();
        chk("unarmed_rd_err_a", int'(err_a), 1);
        chk("unarmed_rd_tx_a",  int'(tx_a),  0);
        chk("unarmed_rd_err_b", int'(err_b), 1);
        chk("unarmed_rd_tx_b",  int'(tx_b),  0);

        for (int a = 0; a < 256; a++) begin
            step(0, a);
            step(1, int'($urandom_range(0, 255)));
        end

        // burst write/read
        step(0, 'h10);
        step(1, 'hA1);
        step(1, 'hB2);
        step(1, 'hC3);
        step(2, 'h10);
        step(3, 0);
        step(3, 0);
        chk("burst0_tx", int'(tx_a), 1);
        chk("burst0", int'(dout_a), 'hA1);
        step(3, 0);
        chk("burst1", int'(dout_a), 'hB2);
        idle();
        chk("burst2_tx", int'(tx_a), 1);
        chk("burst2", int'(dout_a), 'hC3);
        chk("burst_b_hold", int'(dout_b), 'hC3);
        idle();
        chk("burst_end_tx", int'(tx_a), 0);

        // wrap at DEPTH-1
        step(0, 'hC7);
        step(1, 'h55);
        step(1, 'h66);
        step(2, 'hC7);
        step(3, 0);
        step(3, 0);
        chk("wrap_last", int'(dout_a), 'h55);
        idle();
        chk("wrap_zero", int'(dout_a), 'h66);

        // out of range and unarmed
        step(0, 'hC8);
        idle();
        chk("oor_waddr_err", int'(err_a), 1);
        step(1, 'h77);
        idle();
        chk("unarmed_wr_err", int'(err_a), 1);
        step(2, 'hC8);
        idle();
        chk("oor_raddr_err", int'(err_a), 1);
        step(3, 0);
        idle();
        chk("disarmed_rd_err", int'(err_a), 1);
        chk("disarmed_rd_tx",  int'(tx_a),  0);

        // output stage latency
        step(0, 6);
        step(1, 'hC3);
        step(0, 5);
        step(1, 'h3C);
        step(2, 5);
        step(3, 0);
        step(3, 0);
        chk("pipe_early_tx", int'(tx_b), 0);
        chk("pipe_a_first", int'(dout_a), 'h3C);
        idle();
        chk("pipe_tx0", int'(tx_b), 1);
        chk("pipe_d0", int'(dout_b), 'h3C);
        chk("pipe_a_next", int'(dout_a), 'hC3);
        idle();
        chk("pipe_tx1", int'(tx_b), 1);
        chk("pipe_d1", int'(dout_b), 'h3C);
        idle();
        chk("pipe_done", int'(tx_b), 0);

        // rx_valid gating
        step(0, 'h20);
        step(1, 'h99);
        @(negedge clk);
        rx_valid = 1'b0;
        din = {2'b01, 8'hEE};
        idle();
        chk("gate_err_b", int'(err_b), 0);
        chk("gate_tx_b",  int'(tx_b),  0);
        step(2, 'h20);
        step(3, 0);
        idle();
        chk("gate_a", int'(dout_a), 'h99);
        idle();
        chk("gate_b", int'(dout_b), 'h99);

        // reset while a pipelined read is in flight
        step(2, 5);
        step(3, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_dout_b", int'(dout_b), 0);
        chk("rst_tx_b",   int'(tx_b),   0);
        chk("rst_err_b",  int'(err_b),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_tx_b", int'(tx_b), 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rx_valid = ($urandom_range(0, 9) < 8);
            din = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
        end
        repeat (4) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
